// File: rtl/reg_read_stage_pkg.sv
// reg_read_stage_pkg: shared widths, index/data types and the ID/EX boundary record.
package reg_read_stage_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       xlen_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     reg_write;
    xlen_t    rs1_data;
    xlen_t    rs2_data;
  } id_ex_t;

  // Combinational read with x0 hardwired to zero and same-cycle writeback bypass.
  function automatic xlen_t bypass_read(reg_idx_t idx, logic we, reg_idx_t wr, xlen_t wd, xlen_t stored);
    return (idx == '0) ? '0 : (we && wr == idx) ? wd : stored;
  endfunction
endpackage

// File: rtl/reg_read_stage_register_file.sv
// register_file: 32 x XLEN integer registers, two bypassed combinational reads, one write port.
module register_file
  import reg_read_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_we,
  input  reg_idx_t i_waddr,
  input  xlen_t    i_wdata,
  input  reg_idx_t i_raddr1,
  input  reg_idx_t i_raddr2,
  output xlen_t    o_rdata1,
  output xlen_t    o_rdata2
);
  xlen_t r_regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we && i_waddr != '0) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = bypass_read(i_raddr1, i_we, i_waddr, i_wdata, r_regs[i_raddr1]);
  assign o_rdata2 = bypass_read(i_raddr2, i_we, i_waddr, i_wdata, r_regs[i_raddr2]);
endmodule

// File: rtl/reg_read_stage.sv
// reg_read_stage: register-read stage owning the register file and the ID/EX pipeline register
// with flush > stall > load priority and writeback refresh of stalled operands.
module reg_read_stage
  import reg_read_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     id_valid,
  output logic     id_ready,
  input  reg_idx_t id_rs1,
  input  reg_idx_t id_rs2,
  input  reg_idx_t id_rd,
  input  logic     id_reg_write,
  input  logic     stall,
  input  logic     flush,
  input  logic     wb_we,
  input  reg_idx_t wb_rd,
  input  xlen_t    wb_data,
  output logic     ex_valid,
  output reg_idx_t ex_rs1,
  output reg_idx_t ex_rs2,
  output reg_idx_t ex_rd,
  output logic     ex_reg_write,
  output xlen_t    ex_rs1_data,
  output xlen_t    ex_rs2_data
);
  xlen_t  w_rdata1;
  xlen_t  w_rdata2;
  logic   w_wb_live;
  id_ex_t r_ex;

  register_file u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (wb_we),
    .i_waddr  (wb_rd),
    .i_wdata  (wb_data),
    .i_raddr1 (id_rs1),
    .i_raddr2 (id_rs2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  assign w_wb_live = wb_we && wb_rd != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex <= '0;
    end else if (flush) begin
      r_ex.valid     <= 1'b0;
      r_ex.reg_write <= 1'b0;
    end else if (stall) begin
      // A held entry must not keep a stale operand that writeback just produced.
      if (w_wb_live && wb_rd == r_ex.rs1) r_ex.rs1_data <= wb_data;
      if (w_wb_live && wb_rd == r_ex.rs2) r_ex.rs2_data <= wb_data;
    end else begin
      r_ex <= '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                reg_write: id_valid && id_reg_write, rs1_data: w_rdata1, rs2_data: w_rdata2};
    end
  end

  assign id_ready     = !stall;
  assign ex_valid     = r_ex.valid;
  assign ex_rs1       = r_ex.rs1;
  assign ex_rs2       = r_ex.rs2;
  assign ex_rd        = r_ex.rd;
  assign ex_reg_write = r_ex.reg_write;
  assign ex_rs1_data  = r_ex.rs1_data;
  assign ex_rs2_data  = r_ex.rs2_data;
endmodule
